// File: rtl/uart_rx_cmd_ctrl.sv
// Command sequencer behind the UART receiver: parses byte frames into register-file and ALU strobes
// and returns read data / ALU results to the TX FIFO. Define CMD_TIMEOUT_EN to add an inter-byte watchdog.
module uart_rx_cmd_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RF_RdData,
    input  logic                    RF_RdData_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    FIFO_FULL,
    output logic                    RF_WrEn,
    output logic                    RF_RdEn,
    output logic [ADDR_WIDTH-1:0]   RF_Address,
    output logic [DATA_WIDTH-1:0]   RF_WrData,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    CMD_ERR
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, SEND_RD,
        OP_A, OP_B, ALU_FUN_ST, ALU_WAIT, SEND_LSB, SEND_MSB
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   wr_addr, wr_addr_nxt;
    logic [DATA_WIDTH-1:0]   rd_data, rd_data_nxt;
    logic [2*DATA_WIDTH-1:0] alu_res, alu_res_nxt;

    logic                    wr_en_nxt, rd_en_nxt, alu_en_nxt, gate_nxt, tx_vld_nxt, err_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [DATA_WIDTH-1:0]   wr_data_nxt, tx_data_nxt;
    logic [FUN_WIDTH-1:0]    fun_nxt;
    logic                    timeout;

`ifdef CMD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] idle_cnt, idle_cnt_nxt;
    logic          partial;

    // Counter only runs in the mid-frame states; any byte or exit clears it.
    always_comb begin
        partial      = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR) ||
                       (state == OP_A)    || (state == OP_B)    || (state == ALU_FUN_ST);
        idle_cnt_nxt = '0;
        timeout      = 1'b0;
        if (partial && !RX_D_VLD) begin
            if (idle_cnt == CW'(TIMEOUT_CYCLES - 1))
                timeout = 1'b1;
            else
                idle_cnt_nxt = idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) idle_cnt <= '0;
        else      idle_cnt <= idle_cnt_nxt;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        wr_addr_nxt = wr_addr;
        rd_data_nxt = rd_data;
        alu_res_nxt = alu_res;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
        alu_en_nxt  = 1'b0;
        gate_nxt    = 1'b0;
        tx_vld_nxt  = 1'b0;
        err_nxt     = 1'b0;
        addr_nxt    = RF_Address;
        wr_data_nxt = RF_WrData;
        fun_nxt     = ALU_FUN;
        tx_data_nxt = TX_P_DATA;

        if (timeout) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end else begin
            case (state)
                IDLE: if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:     state_nxt = WR_ADDR;
                        CMD_RD:     state_nxt = RD_ADDR;
                        CMD_ALU_OP: state_nxt = OP_A;
                        CMD_ALU:    state_nxt = ALU_FUN_ST;
                        default:    err_nxt   = 1'b1;
                    endcase
                end
                WR_ADDR: if (RX_D_VLD) begin
                    wr_addr_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_nxt   = WR_DATA;
                end
                WR_DATA: if (RX_D_VLD) begin
                    wr_en_nxt   = 1'b1;
                    addr_nxt    = wr_addr;
                    wr_data_nxt = RX_P_DATA;
                    state_nxt   = IDLE;
                end
                RD_ADDR: if (RX_D_VLD) begin
                    rd_en_nxt = 1'b1;
                    addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_nxt = RD_WAIT;
                end
                RD_WAIT: if (RF_RdData_VLD) begin
                    rd_data_nxt = RF_RdData;
                    state_nxt   = SEND_RD;
                end
                SEND_RD: if (!FIFO_FULL) begin
                    tx_vld_nxt  = 1'b1;
                    tx_data_nxt = rd_data;
                    state_nxt   = IDLE;
                end
                // Operands land in the two lowest register-file slots.
                OP_A: if (RX_D_VLD) begin
                    wr_en_nxt   = 1'b1;
                    addr_nxt    = '0;
                    wr_data_nxt = RX_P_DATA;
                    state_nxt   = OP_B;
                end
                OP_B: if (RX_D_VLD) begin
                    wr_en_nxt   = 1'b1;
                    addr_nxt    = ADDR_WIDTH'(1);
                    wr_data_nxt = RX_P_DATA;
                    state_nxt   = ALU_FUN_ST;
                end
                ALU_FUN_ST: if (RX_D_VLD) begin
                    alu_en_nxt = 1'b1;
                    gate_nxt   = 1'b1;
                    fun_nxt    = RX_P_DATA[FUN_WIDTH-1:0];
                    state_nxt  = ALU_WAIT;
                end
                // Gate stays open through the cycle after the result arrives.
                ALU_WAIT: begin
                    gate_nxt = 1'b1;
                    if (ALU_OUT_VLD) begin
                        alu_res_nxt = ALU_OUT;
                        state_nxt   = SEND_LSB;
                    end
                end
                SEND_LSB: if (!FIFO_FULL) begin
                    tx_vld_nxt  = 1'b1;
                    tx_data_nxt = alu_res[DATA_WIDTH-1:0];
                    state_nxt   = SEND_MSB;
                end
                SEND_MSB: if (!FIFO_FULL) begin
                    tx_vld_nxt  = 1'b1;
                    tx_data_nxt = alu_res[2*DATA_WIDTH-1:DATA_WIDTH];
                    state_nxt   = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            wr_addr     <= '0;
            rd_data     <= '0;
            alu_res     <= '0;
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            RF_Address  <= '0;
            RF_WrData   <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
            CMD_ERR     <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_addr     <= wr_addr_nxt;
            rd_data     <= rd_data_nxt;
            alu_res     <= alu_res_nxt;
            RF_WrEn     <= wr_en_nxt;
            RF_RdEn     <= rd_en_nxt;
            RF_Address  <= addr_nxt;
            RF_WrData   <= wr_data_nxt;
            ALU_EN      <= alu_en_nxt;
            ALU_FUN     <= fun_nxt;
            CLK_GATE_EN <= gate_nxt;
            TX_P_DATA   <= tx_data_nxt;
            TX_D_VLD    <= tx_vld_nxt;
            CMD_ERR     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Directed bench for uart_rx_cmd_ctrl: a frame-level model predicts every strobe, checked each cycle,
// plus literal expectations at key points of each scenario.
module tb_uart_rx_cmd_ctrl;
    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [7:0]  RF_RdData;
    logic        RF_RdData_VLD;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        FIFO_FULL;
    logic        RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD, CMD_ERR;
    logic [3:0]  RF_Address, ALU_FUN;
    logic [7:0]  RF_WrData, TX_P_DATA;

    uart_rx_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---- frame-level model: expectations for the cycle after each edge ----
    logic [7:0] frame[$];
    logic [7:0] txq[$];
    int         wait_k = 0;   // 0 none, 1 read data, 2 ALU result
    int         idle = 0;
    bit         started = 0;
    logic       e_rst = 1, e_wr = 0, e_rd = 0, e_alu = 0, e_err = 0, e_tx = 0, e_gate = 0;
    logic [3:0] e_addr = 0, e_fun = 0;
    logic [7:0] e_wdata = 0, e_txd = 0;

    task automatic model_step();
        int  wk0;
        bit  alu_now;
        e_rst = 0; e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0; e_tx = 0;
        alu_now = 0;
        if (!RST) begin
            frame.delete(); txq.delete(); wait_k = 0; idle = 0;
            e_rst = 1; e_gate = 0;
            return;
        end
        wk0 = wait_k;
        if (txq.size() != 0) begin
            if (!FIFO_FULL) begin e_tx = 1; e_txd = txq.pop_front(); end
        end else if (wait_k == 1) begin
            if (RF_RdData_VLD) begin txq.push_back(RF_RdData); wait_k = 0; end
        end else if (wait_k == 2) begin
            if (ALU_OUT_VLD) begin
                txq.push_back(ALU_OUT[7:0]); txq.push_back(ALU_OUT[15:8]); wait_k = 0;
            end
        end else if (RX_D_VLD) begin
            idle = 0;
            frame.push_back(RX_P_DATA);
            case (frame[0])
                8'hAA: if (frame.size() == 3) begin
                    e_wr = 1; e_addr = frame[1][3:0]; e_wdata = frame[2]; frame.delete();
                end
                8'hBB: if (frame.size() == 2) begin
                    e_rd = 1; e_addr = frame[1][3:0]; wait_k = 1; frame.delete();
                end
                8'hCC: begin
                    if (frame.size() == 2) begin e_wr = 1; e_addr = 4'd0; e_wdata = frame[1]; end
                    else if (frame.size() == 3) begin e_wr = 1; e_addr = 4'd1; e_wdata = frame[2]; end
                    else if (frame.size() == 4) begin
                        e_alu = 1; alu_now = 1; e_fun = frame[3][3:0]; wait_k = 2; frame.delete();
                    end
                end
                8'hDD: if (frame.size() == 2) begin
                    e_alu = 1; alu_now = 1; e_fun = frame[1][3:0]; wait_k = 2; frame.delete();
                end
                default: begin e_err = 1; frame.delete(); end
            endcase
        end else if (frame.size() != 0) begin
`ifdef CMD_TIMEOUT_EN
            idle++;
            if (idle == TO) begin e_err = 1; frame.delete(); idle = 0; end
`endif
        end
        e_gate = alu_now || (wk0 == 2);
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
        started = 1;
    end

    // ---- compare process + pulse monitors ----
    int n_wr = 0, n_rd = 0, n_alu = 0, n_err = 0;
    logic [7:0] tx_log[$];

    initial forever begin
        @(negedge CLK);
        if (started) begin
            if (e_rst) begin
                check("rst_outs", {RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD, CMD_ERR}, 0);
                check("rst_data", {RF_Address, RF_WrData, ALU_FUN, TX_P_DATA}, 0);
            end else begin
                check("RF_WrEn", RF_WrEn, e_wr);
                check("RF_RdEn", RF_RdEn, e_rd);
                check("ALU_EN", ALU_EN, e_alu);
                check("CMD_ERR", CMD_ERR, e_err);
                check("CLK_GATE_EN", CLK_GATE_EN, e_gate);
                check("TX_D_VLD", TX_D_VLD, e_tx);
                if (e_wr) check("wr_addr_data", {RF_Address, RF_WrData}, {e_addr, e_wdata});
                if (e_rd) check("rd_addr", RF_Address, e_addr);
                if (e_alu) check("alu_fun", ALU_FUN, e_fun);
                if (e_tx) check("tx_data", TX_P_DATA, e_txd);
                check("strobe_excl", ($countones({RF_WrEn, RF_RdEn, ALU_EN}) <= 1), 1);
            end
        end
        if (RF_WrEn) n_wr++;
        if (RF_RdEn) n_rd++;
        if (ALU_EN) n_alu++;
        if (CMD_ERR) n_err++;
        if (TX_D_VLD) tx_log.push_back(TX_P_DATA);
    end

    // ---- stimulus ----
    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b; RX_D_VLD = 1'b1;
        tick();
        RX_D_VLD = 1'b0;
    endtask

    task automatic pulse_rd(input logic [7:0] d);
        RF_RdData = d; RF_RdData_VLD = 1'b1;
        tick();
        RF_RdData_VLD = 1'b0;
    endtask

    task automatic pulse_alu(input logic [15:0] v);
        ALU_OUT = v; ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        RST = 1'b0; RX_P_DATA = 0; RX_D_VLD = 0; RF_RdData = 0; RF_RdData_VLD = 0;
        ALU_OUT = 0; ALU_OUT_VLD = 0; FIFO_FULL = 0;
        tick(2);
        check("reset_state", {RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD, CMD_ERR,
                              RF_Address, RF_WrData, ALU_FUN, TX_P_DATA}, 0);
        RST = 1'b1;
        tick();

        // write frame
        n0 = n_wr;
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        check("wr_pulse", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'h5, 8'h3C});
        tick();
        check("wr_single", n_wr - n0, 1);

        // read frame
        tx_log.delete();
        send_byte(8'hBB); send_byte(8'h05);
        check("rd_pulse", {RF_RdEn, RF_Address}, {1'b1, 4'h5});
        tick(2);
        pulse_rd(8'h3C);
        tick(3);
        check("rd_tx_count", tx_log.size(), 1);
        if (tx_log.size() == 1) check("rd_tx_byte", tx_log[0], 8'h3C);

        // ALU with operands
        tx_log.delete(); n0 = n_wr;
        send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
        check("alu_en", {ALU_EN, ALU_FUN, CLK_GATE_EN}, {1'b1, 4'h0, 1'b1});
        check("op_writes", n_wr - n0, 2);
        tick(3);
        check("gate_wait", CLK_GATE_EN, 1);
        pulse_alu(16'h0046);
        check("gate_after_vld", CLK_GATE_EN, 1);
        tick();
        check("gate_closed", CLK_GATE_EN, 0);
        tick(3);
        check("alu_tx_count", tx_log.size(), 2);
        if (tx_log.size() == 2) check("alu_tx_bytes", {tx_log[0], tx_log[1]}, 16'h4600);

        // stray valids in IDLE are ignored
        pulse_rd(8'h99); pulse_alu(16'h1234);
        tick(3);

        // ALU without operands under backpressure; stray RX bytes dropped while busy
        tx_log.delete();
        FIFO_FULL = 1'b1;
        send_byte(8'hDD); send_byte(8'h02);
        check("alu_fun_2", ALU_FUN, 4'h2);
        send_byte(8'hAA);
        pulse_alu(16'hABCD);
        send_byte(8'hAA);
        tick(8);
        check("bp_no_tx", tx_log.size(), 0);
        FIFO_FULL = 1'b0;
        tick();
        FIFO_FULL = 1'b1;
        tick(3);
        FIFO_FULL = 1'b0;
        tick(4);
        check("bp_tx_count", tx_log.size(), 2);
        if (tx_log.size() == 2) check("bp_tx_bytes", {tx_log[0], tx_log[1]}, 16'hCDAB);

        // unknown command
        n0 = n_wr;
        send_byte(8'h7F);
        check("cmd_err", {CMD_ERR, RF_WrEn, RF_RdEn, ALU_EN}, 4'b1000);
        tick();

        // reset mid-frame
        send_byte(8'hAA); send_byte(8'h03);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        check("midframe_reset", {RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD, CMD_ERR,
                                 RF_Address, RF_WrData, ALU_FUN, TX_P_DATA}, 0);
        send_byte(8'h3C);
        check("post_reset_3c", {RF_WrEn, CMD_ERR}, 2'b01);
        tick(2);

        // address / function truncation
        send_byte(8'hAA); send_byte(8'hF7); send_byte(8'h5A);
        check("addr_trunc", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'h7, 8'h5A});
        send_byte(8'hDD); send_byte(8'h1F);
        check("fun_trunc", {ALU_EN, ALU_FUN}, {1'b1, 4'hF});
        tick(2);
        pulse_alu(16'h0102);
        tick(5);

`ifdef CMD_TIMEOUT_EN
        n0 = n_rd;
        send_byte(8'hBB);
        tick(TO - 1);
        check("to_not_yet", CMD_ERR, 0);
        tick();
        check("to_err", CMD_ERR, 1);
        check("to_no_rd", n_rd - n0, 0);
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
        check("to_then_idle", {RF_WrEn, RF_Address}, {1'b1, 4'h2});
`else
        send_byte(8'hAA);
        tick(40);
        send_byte(8'h09); send_byte(8'h11);
        check("no_timeout_wr", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'h9, 8'h11});
`endif
        tick(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
